// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 Set-2 key decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;

  // Keyboard housekeeping replies that never describe a key.
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } ps2_prefix_t;

  function automatic logic is_discard(input logic [7:0] b);
    return (b == PS2_BAT_OK) || (b == PS2_ACK)  || (b == PS2_RESEND) ||
           (b == PS2_ECHO)   || (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 receive front end: synchronisers, clock deglitch filter, 11-bit
// frame capture with start/parity/stop check, and partial-frame timeout.
// Emits registered one-cycle strobes one clk after the stop-bit edge.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       rx_error
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);

  logic [1:0]    clk_sync_q, data_sync_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall;
  logic [9:0]    shift_q, shift_d;
  logic [10:0]   frame;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] idle_q, idle_d;
  logic          byte_valid_q, byte_valid_d;
  logic          rx_error_q, rx_error_d;
  logic [7:0]    rx_byte_q, rx_byte_d;

  // Two-flop synchronisers; the bus idles high so reset to 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
    end
  end

  // Flip the filtered clock only after FILTER_LEN consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (fcnt_q == FILT_LAST) filt_d = ~filt_q;
      else                     fcnt_d = fcnt_q + 1'b1;
    end
  end

  assign fall  = filt_q & ~filt_d;
  // Complete frame as it would look after this edge: [0]=start .. [10]=stop.
  assign frame = {data_sync_q[1], shift_q};

  // Bit capture, frame check at bit 10, and idle timeout inside a frame.
  always_comb begin
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    idle_d       = idle_q;
    rx_byte_d    = rx_byte_q;
    byte_valid_d = 1'b0;
    rx_error_d   = 1'b0;
    if (fall) begin
      shift_d = frame[10:1];
      idle_d  = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = '0;
        if (!frame[0] && frame[10] && (^frame[9:1])) begin
          byte_valid_d = 1'b1;
          rx_byte_d    = frame[8:1];
        end else begin
          rx_error_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (idle_q == TO_MAX) begin
        rx_error_d = 1'b1;
        bit_cnt_d  = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  // Filter, capture and check registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q       <= 1'b1;
      fcnt_q       <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      idle_q       <= '0;
      rx_byte_q    <= '0;
      byte_valid_q <= 1'b0;
      rx_error_q   <= 1'b0;
    end else begin
      filt_q       <= filt_d;
      fcnt_q       <= fcnt_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      idle_q       <= idle_d;
      rx_byte_q    <= rx_byte_d;
      byte_valid_q <= byte_valid_d;
      rx_error_q   <= rx_error_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign rx_byte    = rx_byte_q;
  assign rx_error   = rx_error_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns PS/2 Set-2 bytes into press/release key events.
// state   | meaning
// IDLE    | no prefix pending
// BRK     | F0 seen, next code is a release
// EXT     | E0 seen, next code is an extended press (or F0 follows)
// EXT_BRK | E0 F0 seen, next code is an extended release
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       pressed,
  output logic       extended,
  output logic       valid,
  output logic       frame_error
);

  logic        byte_valid, rx_error;
  logic [7:0]  rx_byte;
  ps2_prefix_t state_q, state_d;
  logic [7:0]  code_q, code_d;
  logic        pressed_q, pressed_d;
  logic        extended_q, extended_d;
  logic        valid_q, valid_d;
  logic        frame_error_q, frame_error_d;

  ps2_rx_frame #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .rx_error   (rx_error)
  );

  // Prefix tracking; errors and housekeeping bytes drop any pending prefix.
  always_comb begin
    state_d       = state_q;
    code_d        = code_q;
    pressed_d     = pressed_q;
    extended_d    = extended_q;
    valid_d       = 1'b0;
    frame_error_d = rx_error;
    if (rx_error) begin
      state_d = IDLE;
    end else if (byte_valid) begin
      if (is_discard(rx_byte)) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (rx_byte == PS2_BREAK)    state_d = BRK;
            else if (rx_byte == PS2_EXT) state_d = EXT;
            else begin
              valid_d    = 1'b1;
              code_d     = rx_byte;
              pressed_d  = 1'b1;
              extended_d = 1'b0;
            end
          end
          BRK: begin
            state_d = IDLE;
            if (rx_byte != PS2_EXT) begin
              valid_d    = 1'b1;
              code_d     = rx_byte;
              pressed_d  = 1'b0;
              extended_d = 1'b0;
            end
          end
          EXT: begin
            if (rx_byte == PS2_BREAK) state_d = EXT_BRK;
            else begin
              state_d    = IDLE;
              valid_d    = 1'b1;
              code_d     = rx_byte;
              pressed_d  = 1'b1;
              extended_d = 1'b1;
            end
          end
          EXT_BRK: begin
            state_d = IDLE;
            if (rx_byte != PS2_EXT) begin
              valid_d    = 1'b1;
              code_d     = rx_byte;
              pressed_d  = 1'b0;
              extended_d = 1'b1;
            end
          end
        endcase
      end
    end
  end

  // FSM state and held event outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      code_q        <= '0;
      pressed_q     <= 1'b0;
      extended_q    <= 1'b0;
      valid_q       <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      code_q        <= code_d;
      pressed_q     <= pressed_d;
      extended_q    <= extended_d;
      valid_q       <= valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign code        = code_q;
  assign pressed     = pressed_q;
  assign extended    = extended_q;
  assign valid       = valid_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: bit-level PS/2 driver, event monitor and a
// prefix-flag reference model of the make/break/extended rules.
module tb_ps2_key_decoder;

  localparam int FILT = 8;
  localparam int TMO  = 400;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] code;
  logic       pressed, extended, valid, frame_error;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] c;
    logic       p;
    logic       e;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];
  ev_t last_exp = '0;
  ev_t last_out = '0;
  int  err_seen = 0;
  int  exp_errs = 0;
  int  overlap = 0;
  int  hold_viol = 0;
  bit  m_brk = 0;
  bit  m_ext = 0;

  always #5 clk = ~clk;

  ps2_key_decoder #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .code        (code),
    .pressed     (pressed),
    .extended    (extended),
    .valid       (valid),
    .frame_error (frame_error)
  );

  // Monitor: record events, error strobes, overlaps and output changes without valid.
  always @(negedge clk) begin
    if (reset_n) begin
      if (valid) obs_q.push_back(ev_t'{code, pressed, extended});
      if (frame_error) err_seen <= err_seen + 1;
      if (valid && frame_error) overlap <= overlap + 1;
      if (!valid && (ev_t'{code, pressed, extended} != last_out)) hold_viol <= hold_viol + 1;
    end
    last_out <= ev_t'{code, pressed, extended};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  // Reference model: prefixes are two flags, any key code consumes them.
  task automatic model_byte(input logic [7:0] b);
    if (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}) begin
      m_brk = 0; m_ext = 0;
    end else if (b == 8'hF0 && !m_brk) begin
      m_brk = 1;
    end else if (b == 8'hE0 && m_brk) begin
      m_brk = 0; m_ext = 0;
    end else if (b == 8'hE0 && !m_ext) begin
      m_ext = 1;
    end else begin
      last_exp = ev_t'{b, !m_brk, m_ext};
      exp_q.push_back(last_exp);
      m_brk = 0; m_ext = 0;
    end
  endtask

  task automatic model_error();
    exp_errs++;
    m_brk = 0; m_ext = 0;
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    @(negedge clk);
    ps2_data = b;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
    if (glitch) begin
      ps2_clk = 1'b0;
      repeat (FILT - 1) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (20) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i], glitch);
  endtask

  task automatic check_frame(input string tag);
    ev_t o, e;
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_nev"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_ev"}, 32'(o), 32'(e));
    end
    obs_q.delete();
    exp_q.delete();
    chk({tag, "_err"}, err_seen, exp_errs);
    chk({tag, "_hold"}, 32'(ev_t'{code, pressed, extended}), 32'(last_exp));
  endtask

  task automatic good(input logic [7:0] b, input string tag);
    send_frame(b, 1'b0, 1'b0, 11);
    model_byte(b);
    check_frame(tag);
  endtask

  initial begin
    logic [7:0] disc [6];
    logic [7:0] b;
    int r;
    disc[0] = 8'hAA; disc[1] = 8'hFA; disc[2] = 8'hFE;
    disc[3] = 8'hEE; disc[4] = 8'h00; disc[5] = 8'hFF;

    repeat (3) @(negedge clk);
    chk("rst_code", code, 8'h00);
    chk("rst_flags", {pressed, extended, valid, frame_error}, 4'b0000);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    good(8'h15, "make15");
    good(8'hF0, "brk_pre");
    good(8'h15, "brk15");
    good(8'hE0, "ext_pre");
    good(8'h75, "ext75");
    good(8'hE0, "extb_pre1");
    good(8'hF0, "extb_pre2");
    good(8'h75, "extb75");

    send_frame(8'h2C, 1'b1, 1'b0, 11);
    model_error();
    check_frame("badpar");
    good(8'h16, "after_bad");

    good(8'hE0, "disc_pre");
    good(8'hAA, "disc_aa");
    good(8'h15, "after_disc");

    good(8'hF0, "to_pre");
    send_frame(8'h33, 1'b0, 1'b0, 5);
    repeat (TMO + 10) @(negedge clk);
    model_error();
    check_frame("timeout");
    good(8'h16, "after_to");

    send_frame(8'h1C, 1'b0, 1'b1, 11);
    model_byte(8'h1C);
    check_frame("glitch1c");

    good(8'h1C, "typematic");

    good(8'hF0, "rst_pre");
    send_frame(8'h44, 1'b0, 1'b0, 5);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_code", code, 8'h00);
    chk("midrst_flags", {pressed, extended, valid, frame_error}, 4'b0000);
    reset_n = 1'b1;
    m_brk = 0; m_ext = 0;
    last_exp = '0;
    obs_q.delete();
    repeat (5) @(negedge clk);
    good(8'h15, "after_rst");

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 99);
      if (r < 20)      b = 8'hF0;
      else if (r < 35) b = 8'hE0;
      else if (r < 45) b = disc[$urandom_range(0, 5)];
      else             b = 8'($urandom_range(0, 255));
      if (r >= 92) begin
        send_frame(b, 1'b1, 1'b0, 11);
        model_error();
        check_frame("rnd_bad");
      end else begin
        good(b, "rnd");
      end
    end

    chk("overlap", overlap, 0);
    chk("hold_viol", hold_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
